// File: rtl/snake_step_ctrl.sv
// snake_step_ctrl: game sequencer for the snake datapath.
// Converts refresh pulses and direction levels into discrete moves, keeps the
// body segments in a register array, scans for collisions one segment per
// cycle and grows the snake when the head lands on the food cell.
// Optional feature: define SNAKE_WRAP_EN to make the grid edges wrap around
// instead of killing the snake.
module snake_step_ctrl #(
    parameter int GRID_W   = 32,
    parameter int GRID_H   = 24,
    parameter int MAX_LEN  = 16,
    parameter int STEP_DIV = 8
) (
    input  logic       vga_clk,
    input  logic       rst,
    input  logic       refresh,
    input  logic       start_in,
    input  logic       up_in,
    input  logic       down_in,
    input  logic       left_in,
    input  logic       right_in,
    input  logic [4:0] food_x,
    input  logic [4:0] food_y,
    input  logic [3:0] rd_idx,
    output logic [4:0] rd_x,
    output logic [4:0] rd_y,
    output logic       rd_valid,
    output logic [4:0] head_x,
    output logic [4:0] head_y,
    output logic [4:0] length,
    output logic [1:0] state_out,
    output logic       food_eaten,
    output logic       game_over
);

    localparam int         CNT_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);
    localparam logic [4:0] MAX_X    = 5'(GRID_W - 1);
    localparam logic [4:0] MAX_Y    = 5'(GRID_H - 1);
    localparam logic [4:0] START_X  = 5'(GRID_W / 2);
    localparam logic [4:0] START_Y  = 5'(GRID_H / 2);
    localparam logic [4:0] LEN_MAX  = 5'(MAX_LEN);

`ifdef SNAKE_WRAP_EN
    localparam bit WALLS_KILL = 1'b0;
`else
    localparam bit WALLS_KILL = 1'b1;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_MOVE,
        S_CHECK,
        S_COMMIT,
        S_DEAD
    } state_t;

    typedef enum logic [1:0] {
        D_UP,
        D_DOWN,
        D_LEFT,
        D_RIGHT
    } dir_t;

    state_t           state;
    dir_t             dir;
    dir_t             pending_dir;
    dir_t             req_dir;
    logic             req_valid;
    logic [CNT_W-1:0] step_cnt;
    logic [3:0]       scan_idx;
    logic [4:0]       cand_x;
    logic [4:0]       cand_y;
    logic [4:0]       step_x;
    logic [4:0]       step_y;
    logic             wall_hit;
    logic             cand_hit;
    logic             last_scan;
    logic             eat;
    logic [4:0]       seg_x [0:15];
    logic [4:0]       seg_y [0:15];

    function automatic dir_t opposite(input dir_t d);
        case (d)
            D_UP:    return D_DOWN;
            D_DOWN:  return D_UP;
            D_LEFT:  return D_RIGHT;
            default: return D_LEFT;
        endcase
    endfunction

    // Highest-priority direction request this cycle (up > down > left > right).
    always_comb begin
        req_valid = 1'b1;
        req_dir   = D_RIGHT;
        if (up_in)
            req_dir = D_UP;
        else if (down_in)
            req_dir = D_DOWN;
        else if (left_in)
            req_dir = D_LEFT;
        else if (right_in)
            req_dir = D_RIGHT;
        else
            req_valid = 1'b0;
    end

    // Next head cell along pending_dir; edges wrap here, wall_hit flags the crossing.
    always_comb begin
        step_x   = seg_x[0];
        step_y   = seg_y[0];
        wall_hit = 1'b0;
        case (pending_dir)
            D_UP: begin
                if (seg_y[0] == 5'd0) begin
                    wall_hit = 1'b1;
                    step_y   = MAX_Y;
                end else begin
                    step_y = seg_y[0] - 5'd1;
                end
            end
            D_DOWN: begin
                if (seg_y[0] == MAX_Y) begin
                    wall_hit = 1'b1;
                    step_y   = 5'd0;
                end else begin
                    step_y = seg_y[0] + 5'd1;
                end
            end
            D_LEFT: begin
                if (seg_x[0] == 5'd0) begin
                    wall_hit = 1'b1;
                    step_x   = MAX_X;
                end else begin
                    step_x = seg_x[0] - 5'd1;
                end
            end
            default: begin
                if (seg_x[0] == MAX_X) begin
                    wall_hit = 1'b1;
                    step_x   = 5'd0;
                end else begin
                    step_x = seg_x[0] + 5'd1;
                end
            end
        endcase
    end

    // Collision compare for the segment under scan, end-of-scan and growth decisions.
    always_comb begin
        cand_hit  = (cand_x == seg_x[scan_idx]) && (cand_y == seg_y[scan_idx]);
        last_scan = ({1'b0, scan_idx} == (length - 5'd2));
        eat       = (cand_x == food_x) && (cand_y == food_y) && (length < LEN_MAX);
    end

    // Game sequencer: init, step counting, move/check/commit and death.
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            state       <= S_IDLE;
            dir         <= D_RIGHT;
            pending_dir <= D_RIGHT;
            step_cnt    <= '0;
            scan_idx    <= '0;
            cand_x      <= '0;
            cand_y      <= '0;
            length      <= '0;
            food_eaten  <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                seg_x[i] <= '0;
                seg_y[i] <= '0;
            end
        end else begin
            food_eaten <= 1'b0;
            // Requests reversing onto the neck are dropped; compared to the committed dir.
            if (state != S_IDLE && state != S_DEAD && req_valid && req_dir != opposite(dir))
                pending_dir <= req_dir;
            case (state)
                S_IDLE, S_DEAD: begin
                    if (start_in) begin
                        length      <= 5'd3;
                        seg_x[0]    <= START_X;
                        seg_y[0]    <= START_Y;
                        seg_x[1]    <= START_X - 5'd1;
                        seg_y[1]    <= START_Y;
                        seg_x[2]    <= START_X - 5'd2;
                        seg_y[2]    <= START_Y;
                        dir         <= D_RIGHT;
                        pending_dir <= D_RIGHT;
                        step_cnt    <= '0;
                        state       <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (refresh) begin
                        if (step_cnt == CNT_LAST) begin
                            step_cnt <= '0;
                            state    <= S_MOVE;
                        end else begin
                            step_cnt <= step_cnt + CNT_W'(1);
                        end
                    end
                end
                S_MOVE: begin
                    dir      <= pending_dir;
                    cand_x   <= step_x;
                    cand_y   <= step_y;
                    scan_idx <= '0;
                    if (WALLS_KILL && wall_hit)
                        state <= S_DEAD;
                    else
                        state <= S_CHECK;
                end
                S_CHECK: begin
                    // The tail is never compared: it vacates its cell on this move.
                    if (cand_hit)
                        state <= S_DEAD;
                    else if (last_scan)
                        state <= S_COMMIT;
                    else
                        scan_idx <= scan_idx + 4'd1;
                end
                S_COMMIT: begin
                    // Shifting the whole array leaves the old tail in slot `length` for growth.
                    for (int i = 1; i < 16; i++) begin
                        seg_x[i] <= seg_x[i-1];
                        seg_y[i] <= seg_y[i-1];
                    end
                    seg_x[0] <= cand_x;
                    seg_y[0] <= cand_y;
                    if (eat) begin
                        length     <= length + 5'd1;
                        food_eaten <= 1'b1;
                    end
                    state <= S_RUN;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Registered segment read port for the pixel renderer.
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            rd_x     <= '0;
            rd_y     <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_x     <= seg_x[rd_idx];
            rd_y     <= seg_y[rd_idx];
            rd_valid <= ({1'b0, rd_idx} < length);
        end
    end

    // Status views decoded from registered state.
    always_comb begin
        head_x    = seg_x[0];
        head_y    = seg_y[0];
        game_over = (state == S_DEAD);
        case (state)
            S_IDLE:  state_out = 2'd0;
            S_RUN:   state_out = 2'd1;
            S_DEAD:  state_out = 2'd3;
            default: state_out = 2'd2;
        endcase
    end

endmodule

// File: tb/tb_snake_step_ctrl.sv
// Testbench for snake_step_ctrl: random play against a queue-based snake model,
// with a scoreboard of expected move outcomes and read-port values.
module tb_snake_step_ctrl;

    localparam int GW = 32;
    localparam int GH = 24;
    localparam int ML = 16;
    localparam int SD = 2;

    logic       vga_clk = 1'b0;
    logic       rst;
    logic       refresh;
    logic       start_in;
    logic       up_in, down_in, left_in, right_in;
    logic [4:0] food_x, food_y;
    logic [3:0] rd_idx;
    logic [4:0] rd_x, rd_y;
    logic       rd_valid;
    logic [4:0] head_x, head_y;
    logic [4:0] length;
    logic [1:0] state_out;
    logic       food_eaten;
    logic       game_over;

    snake_step_ctrl #(.GRID_W(GW), .GRID_H(GH), .MAX_LEN(ML), .STEP_DIV(SD)) dut (
        .vga_clk(vga_clk), .rst(rst), .refresh(refresh), .start_in(start_in),
        .up_in(up_in), .down_in(down_in), .left_in(left_in), .right_in(right_in),
        .food_x(food_x), .food_y(food_y), .rd_idx(rd_idx),
        .rd_x(rd_x), .rd_y(rd_y), .rd_valid(rd_valid),
        .head_x(head_x), .head_y(head_y), .length(length),
        .state_out(state_out), .food_eaten(food_eaten), .game_over(game_over)
    );

    always #5 vga_clk = ~vga_clk;

    int cyc = 0;
    always @(posedge vga_clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct { int cyc; int st; int hx; int hy; int len; int fe; } res_t;
    typedef struct { int cyc; int vld; int x; int y; } rd_t;
    res_t sbq[$];
    rd_t  rdq[$];

    // Reference model: body as queues (index 0 = head); dirs 0 up 1 down 2 left 3 right.
    int bx[$];
    int by[$];
    int mdir = 3, mpend = 3, mstep = 0;
    int mst = 0; // 0 idle, 1 running, 3 dead

    function automatic int opp(input int d);
        case (d)
            0: return 1;
            1: return 0;
            2: return 3;
            default: return 2;
        endcase
    endfunction

    // Monitor: pops the expected outcome whenever the DUT leaves BUSY.
    int prev_st = 0;
    always @(negedge vga_clk) begin
        res_t e;
        rd_t r;
        if (prev_st == 2 && state_out != 2'd2) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL move_unexpected actual_state=%0d expected=no_move", state_out);
            end else begin
                e = sbq.pop_front();
                check("move_cycle", cyc, e.cyc);
                check("move_state", int'(state_out), e.st);
                check("move_head_x", int'(head_x), e.hx);
                check("move_head_y", int'(head_y), e.hy);
                check("move_length", int'(length), e.len);
                check("move_food_eaten", int'(food_eaten), e.fe);
                check("move_game_over", int'(game_over), int'(e.st == 3));
            end
        end else begin
            check("food_eaten_quiet", int'(food_eaten), 0);
        end
        if (rdq.size() > 0 && rdq[0].cyc == cyc) begin
            r = rdq.pop_front();
            check("rd_valid", int'(rd_valid), r.vld);
            if (r.vld != 0) begin
                check("rd_x", int'(rd_x), r.x);
                check("rd_y", int'(rd_y), r.y);
            end
        end
        prev_st <= int'(state_out);
    end

    task automatic tick();
        @(negedge vga_clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        bx.delete();
        by.delete();
        mst = 0; mdir = 3; mpend = 3; mstep = 0;
    endtask

    task automatic do_start(input bit with_ref);
        start_in = 1'b1;
        refresh  = with_ref;
        tick();
        start_in = 1'b0;
        refresh  = 1'b0;
        bx.delete();
        by.delete();
        bx.push_back(GW / 2);     by.push_back(GH / 2);
        bx.push_back(GW / 2 - 1); by.push_back(GH / 2);
        bx.push_back(GW / 2 - 2); by.push_back(GH / 2);
        mst = 1; mdir = 3; mpend = 3; mstep = 0;
    endtask

    task automatic drive_dirs(input logic [3:0] m);
        int d;
        {up_in, down_in, left_in, right_in} = m;
        if (mst == 1 && m != 4'd0) begin
            d = m[3] ? 0 : m[2] ? 1 : m[1] ? 2 : 3;
            if (d != opp(mdir)) mpend = d;
        end
        tick();
        {up_in, down_in, left_in, right_in} = 4'd0;
    endtask

    task automatic model_move(input int e0, output bit wall);
        int nx, ny, l;
        bit eat;
        wall = 1'b0;
        mdir = mpend;
        l = bx.size();
        nx = bx[0];
        ny = by[0];
        case (mdir)
            0: ny = ny - 1;
            1: ny = ny + 1;
            2: nx = nx - 1;
            default: nx = nx + 1;
        endcase
`ifdef SNAKE_WRAP_EN
        nx = (nx + GW) % GW;
        ny = (ny + GH) % GH;
`else
        if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) begin
            wall = 1'b1;
            mst = 3;
            sbq.push_back('{e0 + 1, 3, bx[0], by[0], l, 0});
            return;
        end
`endif
        for (int k = 0; k <= l - 2; k++) begin
            if (bx[k] == nx && by[k] == ny) begin
                mst = 3;
                sbq.push_back('{e0 + 2 + k, 3, bx[0], by[0], l, 0});
                return;
            end
        end
        eat = (nx == int'(food_x)) && (ny == int'(food_y)) && (l < ML);
        bx.push_front(nx);
        by.push_front(ny);
        if (!eat) begin
            void'(bx.pop_back());
            void'(by.pop_back());
        end
        sbq.push_back('{e0 + l + 1, 1, nx, ny, bx.size(), int'(eat)});
    endtask

    task automatic wait_sb();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        if (sbq.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL move_timeout pending=%0d expected=0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic do_refresh(input bit busy_dir);
        int  e0;
        bit  q;
        bit  wall;
        e0 = cyc + 1;
        q = 1'b0;
        wall = 1'b0;
        refresh = 1'b1;
        if (mst == 1) begin
            if (mstep == SD - 1) begin
                mstep = 0;
                q = 1'b1;
            end else begin
                mstep++;
            end
        end
        if (q) model_move(e0, wall);
        tick();
        refresh = 1'b0;
        if (q) begin
            if (busy_dir && !wall) begin
                tick();
                drive_dirs(4'($urandom_range(1, 15)));
            end
            wait_sb();
        end
    endtask

    task automatic do_move(input bit busy_dir);
        for (int i = 0; i < SD; i++) do_refresh(busy_dir && (i == SD - 1));
        tick();
    endtask

    task automatic set_food(input int x, input int y);
        food_x = 5'(x);
        food_y = 5'(y);
    endtask

    task automatic food_ahead();
        int nx, ny;
        nx = bx[0];
        ny = by[0];
        case (mpend)
            0: ny = ny - 1;
            1: ny = ny + 1;
            2: nx = nx - 1;
            default: nx = nx + 1;
        endcase
        if (nx >= 0 && nx < GW && ny >= 0 && ny < GH) set_food(nx, ny);
        else set_food($urandom_range(0, GW - 1), $urandom_range(0, GH - 1));
    endtask

    task automatic read_sweep();
        int v, x, y;
        for (int i = 0; i < 16; i++) begin
            rd_idx = 4'(i);
            v = int'(i < bx.size());
            x = (v != 0) ? bx[i] : 0;
            y = (v != 0) ? by[i] : 0;
            rdq.push_back('{cyc + 1, v, x, y});
            tick();
        end
    endtask

    task automatic check_status();
        int est;
        est = (mst == 1) ? 1 : (mst == 3) ? 3 : 0;
        check("status_state", int'(state_out), est);
        check("status_length", int'(length), bx.size());
        check("status_game_over", int'(game_over), int'(mst == 3));
        if (bx.size() > 0) begin
            check("status_head_x", int'(head_x), bx[0]);
            check("status_head_y", int'(head_y), by[0]);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog_timeout cycles=%0d limit=500000", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; refresh = 1'b0; start_in = 1'b0;
        up_in = 1'b0; down_in = 1'b0; left_in = 1'b0; right_in = 1'b0;
        food_x = 5'd0; food_y = 5'd0; rd_idx = 4'd0;
        do_reset();

        // Reset state: every output zero.
        check("reset_head_x", int'(head_x), 0);
        check("reset_head_y", int'(head_y), 0);
        check("reset_length", int'(length), 0);
        check("reset_state", int'(state_out), 0);
        check("reset_food_eaten", int'(food_eaten), 0);
        check("reset_game_over", int'(game_over), 0);
        check("reset_rd_x", int'(rd_x), 0);
        check("reset_rd_y", int'(rd_y), 0);
        check("reset_rd_valid", int'(rd_valid), 0);

        // Refresh in IDLE is ignored; start places the snake at the centre.
        do_refresh(1'b0);
        do_start(1'b0);
        check_status();
        read_sweep();

        // Plain move, rejected reversal, then a turn up.
        set_food(0, 0);
        do_move(1'b0);
        check_status();
        read_sweep();
        drive_dirs(4'b0010);
        do_move(1'b0);
        drive_dirs(4'b1000);
        do_move(1'b0);
        check_status();

        // Growth by one with the old tail kept.
        do_reset();
        do_start(1'b0);
        set_food(GW / 2 + 1, GH / 2);
        do_move(1'b0);
        check_status();
        read_sweep();

        // Grow to MAX_LEN, eat once more at full length, then run into the right edge.
        do_reset();
        do_start(1'b0);
        for (int i = 0; i < 14; i++) begin
            food_ahead();
            do_move(1'b0);
        end
        check_status();
        read_sweep();
        set_food(0, 0);
        do_move(1'b0);
        do_move(1'b0);
        check_status();

        // Grow to 5, then up/left/down into the body.
        do_start(1'b0);
        food_ahead();
        do_move(1'b0);
        food_ahead();
        do_move(1'b0);
        set_food(0, 0);
        drive_dirs(4'b1000);
        do_move(1'b0);
        drive_dirs(4'b0010);
        do_move(1'b0);
        drive_dirs(4'b0100);
        do_move(1'b0);
        check_status();
        read_sweep();
        do_start(1'b1);
        check_status();

        // Reset while scanning: no partial commit, everything back to zero.
        for (int i = 0; i < SD - 1; i++) do_refresh(1'b0);
        refresh = 1'b1;
        tick();
        refresh = 1'b0;
        tick();
        rst = 1'b1;
        sbq.push_back('{cyc + 1, 0, 0, 0, 0, 0});
        tick();
        rst = 1'b0;
        check("rst_busy_length", int'(length), 0);
        check("rst_busy_rd_valid", int'(rd_valid), 0);
        check("rst_busy_rd_x", int'(rd_x), 0);
        check("rst_busy_head_x", int'(head_x), 0);
        bx.delete();
        by.delete();
        mst = 0; mdir = 3; mpend = 3; mstep = 0;
        tick();

        // Random play.
        for (int it = 0; it < 150; it++) begin
            if (mst != 1) begin
                if (mst == 3) do_refresh(1'b0);
                do_start(1'($urandom_range(0, 1)));
                check_status();
            end
            if ($urandom_range(0, 9) < 5) drive_dirs(4'($urandom_range(0, 15)));
            if ($urandom_range(0, 1) == 1) food_ahead();
            else set_food($urandom_range(0, GW - 1), $urandom_range(0, GH - 1));
            for (int s = 0; s < SD; s++) begin
                repeat ($urandom_range(0, 3)) tick();
                do_refresh(($urandom_range(0, 2) == 0) && (s == SD - 1));
            end
            tick();
            check_status();
            if ($urandom_range(0, 3) == 0) read_sweep();
        end

        repeat (4) tick();
        if (sbq.size() != 0 || rdq.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL leftover_expectations actual=%0d expected=0", sbq.size() + rdq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
